sumador_serie: RTL and testbench

Bit-serial N-bit adder with start/done handshake: adds two N-bit operands plus carry-in, one bit per clock, LSB first, using a single registered carry. Additive counterpart of the team's bit-level subtractor. Serves as the low-area add path beside the combinational adder/subtractor chain in the 4-bit arithmetic datapath.

---
 rtl/sumador_serie.sv | 108 ++++++++++
 tb/tb_sumador_serie.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sumador_serie.sv
// Bit-serial N-bit adder, LSB first, single registered carry.
// start/done handshake: ocupado while adding, listo pulses on result.
module sumador_serie #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         ocupado,
  output logic         listo
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] ULT = CW'(N - 1);

  typedef enum logic {
    IDLE,
    SUMA
  } estado_t;

  estado_t estado, estado_d;

  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [N-1:0]  s_sh;
  logic [N-1:0]  s_sh_d;
  logic          carry;
  logic          carry_d;
  logic          bit_s;
  logic [CW-1:0] cnt;
  logic          acepta;
  logic          ultimo;

  always_comb begin
    estado_d = estado;
    acepta   = 1'b0;
    ultimo   = 1'b0;
    bit_s    = a_sh[0] ^ b_sh[0] ^ carry;
    carry_d  = (a_sh[0] & b_sh[0])
             | (a_sh[0] & carry)
             | (b_sh[0] & carry);
    s_sh_d   = {bit_s, s_sh[N-1:1]};
    unique case (estado)
      IDLE: begin
        if (start) begin
          acepta   = 1'b1;
          estado_d = SUMA;
        end
      end
      SUMA: begin
        ultimo = (cnt == ULT);
        if (ultimo) estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) estado <= IDLE;
    else     estado <= estado_d;
  end

  // On the last bit, carry still holds the carry into the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      listo <= 1'b0;
    end else begin
      listo <= 1'b0;
      if (acepta) begin
        a_sh  <= a;
        b_sh  <= b;
        s_sh  <= '0;
        carry <= cin;
        cnt   <= '0;
      end else if (estado == SUMA) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        s_sh  <= s_sh_d;
        carry <= carry_d;
        if (ultimo) begin
          s     <= s_sh_d;
          cout  <= carry_d;
          ovf   <= carry ^ carry_d;
          listo <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign ocupado = (estado == SUMA);

endmodule

// File: tb/tb_sumador_serie.sv
// Bench for sumador_serie: directed scenarios, exhaustive N=4,
// random N=8, all against an integer reference model.
module tb_sumador_serie;

  logic       clk;
  logic       rst;
  logic       start4, cin4;
  logic [3:0] a4, b4, s4;
  logic       cout4, ovf4, ocupado4, listo4;
  logic       start8, cin8;
  logic [7:0] a8, b8, s8;
  logic       cout8, ovf8, ocupado8, listo8;

  int checks;
  int failures;

  sumador_serie #(.N(4)) u4 (
    .clk(clk), .rst(rst), .start(start4),
    .a(a4), .b(b4), .cin(cin4),
    .s(s4), .cout(cout4), .ovf(ovf4),
    .ocupado(ocupado4), .listo(listo4)
  );

  sumador_serie #(.N(8)) u8 (
    .clk(clk), .rst(rst), .start(start8),
    .a(a8), .b(b8), .cin(cin8),
    .s(s8), .cout(cout8), .ovf(ovf8),
    .ocupado(ocupado8), .listo(listo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer add, signed range check for overflow.
  function automatic void model(input int n, input int a, input int b,
                                input int c, output logic [7:0] es,
                                output logic ec, output logic eo);
    int t, sa, sb, st;
    t  = a + b + c;
    es = 8'(t % (1 << n));
    ec = ((t >> n) & 1) != 0;
    sa = (a >= (1 << (n - 1))) ? a - (1 << n) : a;
    sb = (b >= (1 << (n - 1))) ? b - (1 << n) : b;
    st = sa + sb + c;
    eo = (st < -(1 << (n - 1))) || (st > (1 << (n - 1)) - 1);
  endfunction

  task automatic run4(input logic [3:0] ta, input logic [3:0] tb,
                      input logic tc, output logic [3:0] rs,
                      output logic rc, output logic ro,
                      output int lat, output int busy);
    start4 = 1'b1; a4 = ta; b4 = tb; cin4 = tc;
    @(posedge clk); #1;
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    lat  = 1;
    busy = (ocupado4 === 1'b1) ? 1 : 0;
    while (listo4 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (ocupado4 === 1'b1) busy++;
    end
    rs = s4; rc = cout4; ro = ovf4;
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb,
                      input logic tc, output logic [7:0] rs,
                      output logic rc, output logic ro,
                      output int lat);
    start8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = 1;
    while (listo8 !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = s8; rc = cout8; ro = ovf8;
  endtask

  task automatic test_reset();
    rst = 1'b1; start4 = 1'b1; start8 = 1'b1;
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({s4, cout4, ovf4, ocupado4, listo4} !== 8'h00) begin
        failures++;
        $display("FAIL reset4 cyc%0d got s=%b c=%b o=%b busy=%b listo=%b want all 0",
                 i, s4, cout4, ovf4, ocupado4, listo4);
      end
      checks++;
      if ({s8, cout8, ovf8, ocupado8, listo8} !== 12'h000) begin
        failures++;
        $display("FAIL reset8 cyc%0d got s=%h c=%b o=%b busy=%b listo=%b want all 0",
                 i, s8, cout8, ovf8, ocupado8, listo8);
      end
    end
    rst = 1'b0; start4 = 1'b0; start8 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ocupado4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_drop got ocupado=%b want 0", ocupado4);
    end
  endtask

  task automatic test_basic();
    logic [3:0] rs;
    logic rc, ro;
    int lat, busy;
    run4(4'b0111, 4'b0001, 1'b0, rs, rc, ro, lat, busy);
    checks++;
    if ({rs, rc, ro} !== {4'b1000, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL basic got s=%b c=%b o=%b want s=1000 c=0 o=1", rs, rc, ro);
    end
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL basic_latency got %0d want 5", lat);
    end
    checks++;
    if (busy !== 4) begin
      failures++;
      $display("FAIL basic_busy got %0d want 4", busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (listo4 !== 1'b0 || s4 !== 4'b1000 || ocupado4 !== 1'b0) begin
        failures++;
        $display("FAIL basic_hold cyc%0d got listo=%b s=%b busy=%b want 0 1000 0",
                 i, listo4, s4, ocupado4);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] rs;
    logic rc, ro;
    int lat, busy;
    run4(4'b1111, 4'b0001, 1'b0, rs, rc, ro, lat, busy);
    checks++;
    if ({rs, rc, ro} !== {4'b0000, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL wrap got s=%b c=%b o=%b want s=0000 c=1 o=0", rs, rc, ro);
    end
    @(posedge clk); #1;
    run4(4'b0101, 4'b0011, 1'b1, rs, rc, ro, lat, busy);
    checks++;
    if ({rs, rc, ro} !== {4'b1001, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL cin_ovf got s=%b c=%b o=%b want s=1001 c=0 o=1", rs, rc, ro);
    end
  endtask

  task automatic test_busy();
    int pulses;
    logic [3:0] rs;
    logic rc;
    pulses = 0; rs = 'x; rc = 1'bx;
    @(posedge clk); #1;
    start4 = 1'b1; a4 = 4'b0010; b4 = 4'b0011; cin4 = 1'b0;
    @(posedge clk); #1;
    a4 = 4'b1111; b4 = 4'b1111;
    for (int i = 1; i <= 10; i++) begin
      if (i == 4) start4 = 1'b0;
      @(posedge clk); #1;
      if (listo4 === 1'b1) begin
        pulses++;
        rs = s4; rc = cout4;
      end
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL busy_pulses got %0d want 1", pulses);
    end
    checks++;
    if ({rs, rc} !== {4'b0101, 1'b0}) begin
      failures++;
      $display("FAIL busy_result got s=%b c=%b want s=0101 c=0", rs, rc);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] rs;
    logic rc, ro;
    int lat, busy, pulses;
    run4(4'b0001, 4'b0010, 1'b0, rs, rc, ro, lat, busy);
    run4(4'b1000, 4'b1000, 1'b0, rs, rc, ro, lat, busy);
    checks++;
    if ({rs, rc, ro} !== {4'b0000, 1'b1, 1'b1} || lat !== 5) begin
      failures++;
      $display("FAIL b2b got s=%b c=%b o=%b lat=%0d want s=0000 c=1 o=1 lat=5",
               rs, rc, ro, lat);
    end
    start4 = 1'b1; a4 = 4'b0101; b4 = 4'b0110; cin4 = 1'b0;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({s4, cout4, ovf4, ocupado4, listo4} !== 8'h00) begin
      failures++;
      $display("FAIL midreset got s=%b c=%b o=%b busy=%b listo=%b want all 0",
               s4, cout4, ovf4, ocupado4, listo4);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (listo4 === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL midreset_listo got %0d pulses want 0", pulses);
    end
    run4(4'b0011, 4'b0100, 1'b0, rs, rc, ro, lat, busy);
    checks++;
    if ({rs, rc, ro} !== {4'b0111, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL after_reset got s=%b c=%b o=%b want s=0111 c=0 o=0",
               rs, rc, ro);
    end
  endtask

  task automatic test_exhaustive4();
    logic [3:0] rs;
    logic rc, ro, ec, eo;
    logic [7:0] es;
    int lat, busy;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          run4(4'(x), 4'(y), 1'(c), rs, rc, ro, lat, busy);
          model(4, x, y, c, es, ec, eo);
          checks++;
          if (rs !== es[3:0] || rc !== ec || ro !== eo || lat !== 5) begin
            failures++;
            $display("FAIL exh4 %0d+%0d+%0d got s=%b c=%b o=%b lat=%0d want s=%b c=%b o=%b lat=5",
                     x, y, c, rs, rc, ro, lat, es[3:0], ec, eo);
          end
        end
      end
    end
  endtask

  task automatic test_random8();
    logic [7:0] rs, es;
    logic rc, ro, ec, eo;
    int lat, x, y, c;
    for (int i = 0; i < 200; i++) begin
      x = int'($urandom_range(255));
      y = int'($urandom_range(255));
      c = int'($urandom_range(1));
      if (i == 0) begin x = 255; y = 255; c = 1; end
      if (i == 1) begin x = 127; y = 0;   c = 1; end
      run8(8'(x), 8'(y), 1'(c), rs, rc, ro, lat);
      model(8, x, y, c, es, ec, eo);
      checks++;
      if (rs !== es || rc !== ec || ro !== eo || lat !== 9) begin
        failures++;
        $display("FAIL rnd8 %0d+%0d+%0d got s=%h c=%b o=%b lat=%0d want s=%h c=%b o=%b lat=9",
                 x, y, c, rs, rc, ro, lat, es, ec, eo);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; cin4 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_busy();
    test_back_to_back();
    test_exhaustive4();
    test_random8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
